// File: rtl/shift_reg_univ.sv
// shift_reg_univ -- universal shift register with hold, shift right, shift left
// and parallel load. A shift counter tracks progress through a WIDTH-bit frame
// and raises a one-cycle frame_done pulse after every WIDTH-th shift.
//
// Optional feature: define SHIFT_REG_ROTATE_EN to add the rot input. With
// rot=1 the shifts become rotates and the serial inputs are ignored.
// The counter and frame_done behave the same way in both shift and rotate.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNTW-1:0]  shift_cnt,
    output logic             frame_done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Count value at which the next shift completes a frame.
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);

    logic [WIDTH-1:0] q_r;
    logic [CNTW-1:0]  cnt_r;
    logic             frame_done_r;

    logic [WIDTH-1:0] q_next_s;
    logic [CNTW-1:0]  cnt_next_s;
    logic             frame_done_next_s;
    logic             shift_s;
    logic             in_r_s;
    logic             in_l_s;

    // Bits entering the register on each shift direction: the serial pins,
    // or the bit leaving the opposite end when rotating.
`ifdef SHIFT_REG_ROTATE_EN
    assign in_r_s = rot ? q_r[0]       : sin_r;
    assign in_l_s = rot ? q_r[WIDTH-1] : sin_l;
`else
    assign in_r_s = sin_r;
    assign in_l_s = sin_l;
`endif

    // Next-state decode for data, shift counter and frame pulse.
    always_comb begin
        q_next_s          = q_r;
        cnt_next_s        = cnt_r;
        frame_done_next_s = 1'b0;
        shift_s           = 1'b0;

        case (mode)
            MODE_HOLD: begin
                q_next_s = q_r;
            end
            MODE_RIGHT: begin
                q_next_s = {in_r_s, q_r[WIDTH-1:1]};
                shift_s  = 1'b1;
            end
            MODE_LEFT: begin
                q_next_s = {q_r[WIDTH-2:0], in_l_s};
                shift_s  = 1'b1;
            end
            MODE_LOAD: begin
                q_next_s   = din;
                cnt_next_s = CNT_ZERO;
            end
            default: begin
                q_next_s = q_r;
            end
        endcase

        // A direction change keeps counting; only load, reset or wrap clear it.
        if (shift_s) begin
            if (cnt_r == LAST_CNT) begin
                cnt_next_s        = CNT_ZERO;
                frame_done_next_s = 1'b1;
            end else begin
                cnt_next_s        = cnt_r + CNT_ONE;
                frame_done_next_s = 1'b0;
            end
        end else begin
            frame_done_next_s = 1'b0;
        end
    end

    // State register; reset clears everything immediately, abandoning any frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r          <= {WIDTH{1'b0}};
            cnt_r        <= CNT_ZERO;
            frame_done_r <= 1'b0;
        end else begin
            q_r          <= q_next_s;
            cnt_r        <= cnt_next_s;
            frame_done_r <= frame_done_next_s;
        end
    end

    assign q          = q_r;
    assign shift_cnt  = cnt_r;
    assign frame_done = frame_done_r;
    assign sout_r     = q_r[0];
    assign sout_l     = q_r[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8): directed scenarios plus
// randomized operation, all compared against an arithmetic reference model.
// When SHIFT_REG_ROTATE_EN is defined the rotate scenario is exercised as well.
module tb_shift_reg_univ;

    localparam int W = 8;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         clk;
    logic         reset;
    logic [1:0]   mode;
    logic         sin_r;
    logic         sin_l;
`ifdef SHIFT_REG_ROTATE_EN
    logic         rot;
`endif
    logic [W-1:0] din;
    logic [W-1:0] q;
    logic         sout_r;
    logic         sout_l;
    logic [3:0]   shift_cnt;
    logic         frame_done;

    int n_checks;
    int n_pass;

    // Reference model state: register value, shifts into current frame, pulse.
    int unsigned m_q;
    int unsigned m_shifts;
    int unsigned m_fd;

    shift_reg_univ #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
`ifdef SHIFT_REG_ROTATE_EN
        .rot        (rot),
`endif
        .din        (din),
        .q          (q),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q      = 0;
        m_shifts = 0;
        m_fd     = 0;
    endtask

    // Apply one clocked operation to the model using plain arithmetic.
    task automatic model_step();
        int unsigned in_r;
        int unsigned in_l;
        in_r = sin_r;
        in_l = sin_l;
`ifdef SHIFT_REG_ROTATE_EN
        if (rot) begin
            in_r = m_q & 1;
            in_l = (m_q >> (W - 1)) & 1;
        end
`endif
        m_fd = 0;
        if (mode == 2'd1 || mode == 2'd2) begin
            if (mode == 2'd1) m_q = (m_q >> 1) | (in_r << (W - 1));
            else              m_q = ((m_q << 1) | in_l) & MASK;
            m_shifts = m_shifts + 1;
            if (m_shifts == W) begin
                m_fd     = 1;
                m_shifts = 0;
            end
        end else if (mode == 2'd3) begin
            m_q      = din;
            m_shifts = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},          q,          m_q);
        check({tag, ".cnt"},        shift_cnt,  m_shifts);
        check({tag, ".frame_done"}, frame_done, m_fd);
        check({tag, ".sout_r"},     sout_r,     m_q & 1);
        check({tag, ".sout_l"},     sout_l,     (m_q >> (W - 1)) & 1);
    endtask

    // Drive one operation (called at a falling edge), clock it, check at next falling edge.
    task automatic do_op(input string tag, input logic [1:0] m, input logic sr,
                         input logic sl, input logic [W-1:0] d);
        mode  = m;
        sin_r = sr;
        sin_l = sl;
        din   = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    // Assert reset between clock edges, check the immediate clear, release at next falling edge.
    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(negedge clk);
        reset = 1'b0;
        check_all({tag, ".held"});
    endtask

    initial begin
        logic [W-1:0] sr_seq;
        int           pulses;
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        mode  = 2'b00;
        sin_r = 1'b0;
        sin_l = 1'b0;
        din   = '0;
`ifdef SHIFT_REG_ROTATE_EN
        rot   = 1'b0;
`endif
        model_reset();
        #1;
        check_all("reset_start");
        @(negedge clk);
        reset = 1'b0;

        // Immediate clear with nonzero contents.
        do_op("pre_rst_load", 2'b11, 1'b0, 1'b0, 8'h5C);
        pulse_reset("rst_nonzero");

        // Load then hold.
        do_op("load_a5", 2'b11, 1'b0, 1'b0, 8'hA5);
        do_op("hold_a5", 2'b00, 1'b1, 1'b1, 8'h3C);
        check("hold_q_const", q, 32'h0000_00A5);

        // Load 0x81, shift right 8 times; sout_r before each shift follows 1,0,...,0,1.
        do_op("load_81", 2'b11, 1'b0, 1'b0, 8'h81);
        sr_seq = 8'b1000_0001;
        for (int i = 0; i < W; i++) begin
            check("sout_r_seq", sout_r, sr_seq[i]);
            do_op("shr_81", 2'b01, 1'b0, 1'b0, 8'h00);
        end
        check("shr_81_end_q", q, 32'h0);
        check("shr_81_fd", frame_done, 32'h1);
        do_op("after_frame_hold", 2'b00, 1'b0, 1'b0, 8'h00);
        check("fd_one_cycle", frame_done, 32'h0);

        // Mixed direction frame from zero.
        do_op("load_00", 2'b11, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) do_op("shl_ones", 2'b10, 1'b0, 1'b1, 8'h00);
        check("mixed_q_0f", q, 32'h0F);
        for (int i = 0; i < 4; i++) do_op("shr_zero", 2'b01, 1'b0, 1'b0, 8'h00);
        check("mixed_q_00", q, 32'h00);
        check("mixed_fd", frame_done, 32'h1);
        check("mixed_cnt", shift_cnt, 32'h0);

        // Back-to-back frames: pulse every 8 shifts with no gap.
        pulses = 0;
        for (int i = 0; i < 3 * W; i++) begin
            do_op("b2b", 2'b10, 1'b0, i[0], 8'h00);
            if (frame_done) pulses++;
            check("b2b_fd_slot", frame_done, ((i % W) == (W - 1)) ? 32'h1 : 32'h0);
        end
        check("b2b_pulses", pulses, 32'd3);

        // Reset mid-frame abandons the frame.
        do_op("load_0_rst", 2'b11, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) do_op("pre_rst_shift", 2'b01, 1'b1, 1'b0, 8'h00);
        pulse_reset("rst_midframe");
        pulses = 0;
        for (int i = 0; i < W; i++) begin
            do_op("post_rst_shift", 2'b10, 1'b1, 1'b1, 8'h00);
            if (frame_done) pulses++;
        end
        check("post_rst_pulses", pulses, 32'd1);
        check("post_rst_fd_last", frame_done, 32'h1);

`ifdef SHIFT_REG_ROTATE_EN
        // Rotate left a single one through the whole register.
        do_op("rot_load", 2'b11, 1'b0, 1'b0, 8'h01);
        rot = 1'b1;
        for (int i = 0; i < W; i++) begin
            do_op("rotl", 2'b10, 1'b0, 1'b0, 8'h00);
            check("rotl_q", q, (32'h1 << ((i + 1) % W)));
        end
        check("rotl_fd", frame_done, 32'h1);
        rot = 1'b0;
`endif

        // Randomized operation with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                pulse_reset("rand_rst");
            end else begin
`ifdef SHIFT_REG_ROTATE_EN
                rot = 1'($urandom_range(0, 1));
`endif
                do_op("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter: CNTW, default $clog2(WIDTH+1), shift-counter width; derived, SHALL NOT be overridden.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 sin_r  input  1  serial input; enters q[WIDTH-1] on shift right.
REQ-007 sin_l  input  1  serial input; enters q[0] on shift left.
REQ-008 din  input  WIDTH  parallel load data.
REQ-009 q  output  WIDTH  register contents.
REQ-010 sout_r  output  1  equals q[0]; this is the bit shifted out on shift right.
REQ-011 sout_l  output  1  equals q[WIDTH-1]; this is the bit shifted out on shift left.
REQ-012 shift_cnt  output  CNTW  count of shifts since the last load, reset or frame wrap.
REQ-013 frame_done  output  1  one-cycle pulse marking completion of WIDTH shifts.

Function
REQ-014 mode SHALL be sampled on the rising clk edge; q SHALL reflect the operation one cycle later, with no combinational path from din to q.
REQ-015 Hold (00): q and shift_cnt SHALL keep their values; frame_done SHALL be 0.
REQ-016 Shift right (01): q SHALL become {sin_r, q[WIDTH-1:1]}.
REQ-017 Shift left (10): q SHALL become {q[WIDTH-2:0], sin_l}.
REQ-018 Load (11): q SHALL become din, shift_cnt SHALL become 0, and frame_done SHALL be 0.
REQ-019 Each shift (01 or 10) SHALL increment shift_cnt by 1; direction changes SHALL NOT clear the count.
REQ-020 On a shift with shift_cnt == WIDTH-1, shift_cnt SHALL wrap to 0 and frame_done SHALL be 1 for the following cycle only.
REQ-021 frame_done SHALL be registered and 0 in every cycle not covered by REQ-020.
REQ-022 Back-to-back frames with continuous shifting SHALL produce a frame_done pulse every WIDTH cycles, with no gap cycle.
REQ-023 sout_r and sout_l SHALL be combinational decodes of q only.

Reset
REQ-024 While reset is asserted, q SHALL be 0, shift_cnt 0 and frame_done 0, independent of clk.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse.
REQ-026 The first operation after reset deassertion SHALL be taken on the first rising clk edge with reset low.

Configuration
REQ-027 Macro SHIFT_REG_ROTATE_EN: when defined, it SHALL add input port rot (1 bit).
REQ-028 With the macro defined and rot=1, shift right SHALL give {q[0], q[WIDTH-1:1]} and shift left SHALL give {q[WIDTH-2:0], q[WIDTH-1]}. sin_r and sin_l SHALL be ignored, and the counter and frame_done SHALL behave as in REQ-019..REQ-020.
REQ-029 With the macro defined and rot=0, or with the macro undefined, behaviour SHALL be exactly REQ-016..REQ-017. When the macro is undefined, port rot SHALL NOT exist.

Verification (WIDTH=8)
REQ-030 reset=1 with q nonzero -> q=8'h00, shift_cnt=0 and frame_done=0 immediately, before any clk edge.
REQ-031 Load din=8'hA5, then 1 hold cycle -> q=8'hA5 after the load edge and unchanged after the hold; shift_cnt=0.
REQ-032 Load 8'h81, then shift right with sin_r=0 for 8 cycles -> sout_r sequence 1,0,0,0,0,0,0,1; q ends 8'h00; frame_done=1 only in the cycle after the 8th shift.
REQ-033 From q=8'h00, shift left 4 cycles with sin_l=1, then 4 cycles of shift right with sin_r=0 -> q=8'h0F after the 4th left shift, q=8'h00 after the 4th right shift; frame_done pulses once after the 8th shift; shift_cnt=0.
REQ-034 From 0, shift 5 times, assert reset, release, then shift 8 times -> exactly one frame_done pulse, after the 8th post-reset shift.
REQ-035 SHIFT_REG_ROTATE_EN defined: load 8'h01, rot=1, shift left 8 cycles -> q = 02,04,08,10,20,40,80,01 in order; frame_done after the 8th shift.
